// File: rtl/bitty_ctrl.sv
// Bitty CPU control unit: fetches an instruction word, latches it, and walks the
// datapath through LOAD_S/EXEC/WB, MEM or BRANCH with Moore-decoded controls.
module bitty_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] instr,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [2:0]  flags,
   input  logic        mem_ready,
   output logic [3:0]  mux_sel,
   output logic [15:0] imm,
   output logic [2:0]  alu_sel,
   output logic        en_s,
   output logic        en_c,
   output logic [7:0]  en_reg,
   output logic        wb_sel,
   output logic        mem_req,
   output logic        mem_we,
   output logic        pc_inc,
   output logic        pc_load,
   output logic [11:0] pc_target,
   output logic        done,
   output logic [15:0] instr_count
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      LOAD_S = 3'd2,
      EXEC   = 3'd3,
      WB     = 3'd4,
      MEM    = 3'd5,
      BRANCH = 3'd6
   } state_t;

   state_t      state_reg;
   state_t      state_next;
   logic [15:0] instr_reg;
   logic [15:0] instr_count_reg;
   logic        wb_en;
   logic        taken;

   logic [1:0] fmt;
   logic [2:0] rx;
   logic [2:0] ry;
   logic [1:0] cond;

   assign fmt  = instr_reg[1:0];
   assign rx   = instr_reg[15:13];
   assign ry   = instr_reg[12:10];
   assign cond = instr_reg[3:2];

   // Field decodes come only from the latched copy so the source may change after accept.
   assign imm         = {8'h00, instr_reg[12:5]};
   assign alu_sel     = instr_reg[4:2];
   assign pc_target   = instr_reg[15:4];
   assign instr_count = instr_count_reg;

   // flags = {eq, gt, lt}
   always_comb begin
      taken = 1'b0;
      case (cond)
         2'b00:   taken = flags[2];
         2'b01:   taken = flags[1];
         2'b10:   taken = flags[0];
         default: taken = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         instr_reg       <= '0;
         instr_count_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == FETCH && instr_valid)
            instr_reg <= instr;
         if (done)
            instr_count_reg <= instr_count_reg + 16'd1;
      end
   end

   always_comb begin
      state_next  = state_reg;
      instr_ready = 1'b0;
      mux_sel     = 4'd0;
      en_s        = 1'b0;
      en_c        = 1'b0;
      wb_en       = 1'b0;
      wb_sel      = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      pc_inc      = 1'b0;
      pc_load     = 1'b0;
      done        = 1'b0;
      case (state_reg)
         IDLE: state_next = FETCH;
         FETCH: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               case (instr[1:0])
                  2'b10:   state_next = MEM;
                  2'b11:   state_next = BRANCH;
                  default: state_next = LOAD_S;
               endcase
            end
         end
         LOAD_S: begin
            mux_sel    = {1'b0, rx};
            en_s       = 1'b1;
            state_next = EXEC;
         end
         EXEC: begin
            mux_sel    = (fmt == 2'b01) ? 4'd8 : {1'b0, ry};
            en_c       = 1'b1;
            state_next = WB;
         end
         WB: begin
            wb_en      = 1'b1;
            wb_sel     = (fmt == 2'b10);
            pc_inc     = 1'b1;
            done       = 1'b1;
            state_next = FETCH;
         end
         MEM: begin
            mux_sel = {1'b0, ry};
            mem_req = 1'b1;
            mem_we  = instr_reg[2];
            // A store retires in the completing MEM cycle; a load still needs WB.
            if (mem_ready) begin
               if (instr_reg[2]) begin
                  pc_inc     = 1'b1;
                  done       = 1'b1;
                  state_next = FETCH;
               end else begin
                  state_next = WB;
               end
            end
         end
         BRANCH: begin
            pc_load    = taken;
            pc_inc     = !taken;
            done       = 1'b1;
            state_next = FETCH;
         end
         default: state_next = IDLE;
      endcase
   end

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_en_reg
         assign en_reg[gi] = wb_en && (rx == gi[2:0]);
      end
   endgenerate

endmodule

// File: tb/tb_bitty_ctrl.sv
// Self-checking bench for bitty_ctrl: per-instruction expected control traces are
// derived from the instruction-format rules and compared cycle by cycle.
module tb_bitty_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [2:0]  flags;
   logic        mem_ready;
   logic [3:0]  mux_sel;
   logic [15:0] imm;
   logic [2:0]  alu_sel;
   logic        en_s;
   logic        en_c;
   logic [7:0]  en_reg;
   logic        wb_sel;
   logic        mem_req;
   logic        mem_we;
   logic        pc_inc;
   logic        pc_load;
   logic [11:0] pc_target;
   logic        done;
   logic [15:0] instr_count;

   int          checks = 0;
   int          fails = 0;
   logic [15:0] model_count;

   always #5 clk = ~clk;

   bitty_ctrl dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .flags(flags), .mem_ready(mem_ready),
      .mux_sel(mux_sel), .imm(imm), .alu_sel(alu_sel), .en_s(en_s), .en_c(en_c),
      .en_reg(en_reg), .wb_sel(wb_sel), .mem_req(mem_req), .mem_we(mem_we),
      .pc_inc(pc_inc), .pc_load(pc_load), .pc_target(pc_target), .done(done),
      .instr_count(instr_count)
   );

   logic [20:0] obs;
   assign obs = {mux_sel, en_s, en_c, en_reg, wb_sel, mem_req, mem_we,
                 pc_inc, pc_load, done, instr_ready};

   function automatic logic [20:0] ev(input logic [3:0] m, input logic s, input logic c,
                                      input logic [7:0] r, input logic wb, input logic mr,
                                      input logic mw, input logic inc, input logic ld,
                                      input logic dn, input logic rdy);
      return {m, s, c, r, wb, mr, mw, inc, ld, dn, rdy};
   endfunction

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Starts at a negedge in FETCH; ends at a negedge back in FETCH.
   task automatic run_instr(input logic [15:0] ins, input logic [2:0] flg,
                            input int waits, input string tag);
      logic [1:0]  fmt;
      logic [2:0]  rx;
      logic [2:0]  ry;
      logic        store;
      logic        tk;
      logic [20:0] e;
      fmt   = ins[1:0];
      rx    = ins[15:13];
      ry    = ins[12:10];
      store = ins[2];
      case (ins[3:2])
         2'b00:   tk = flg[2];
         2'b01:   tk = flg[1];
         2'b10:   tk = flg[0];
         default: tk = 1'b1;
      endcase
      instr = ins; instr_valid = 1'b1; flags = flg; mem_ready = (waits == 0);
      #1;
      e = ev(0,0,0,0,0,0,0,0,0,0,1);
      checks++;
      if (obs !== e) begin fails++; $display("FAIL %s fetch: got %h expected %h", tag, obs, e); end
      step;
      instr_valid = 1'b0;
      instr = 16'($urandom);
      if (fmt[1] == 1'b0) begin
         #1;
         e = ev({1'b0, rx},1,0,0,0,0,0,0,0,0,0);
         checks++;
         if (obs !== e) begin fails++; $display("FAIL %s load_s: got %h expected %h", tag, obs, e); end
         step;
         #1;
         e = ev((fmt == 2'b01) ? 4'd8 : {1'b0, ry},0,1,0,0,0,0,0,0,0,0);
         checks++;
         if (obs !== e || alu_sel !== ins[4:2] || imm !== {8'h00, ins[12:5]}) begin
            fails++;
            $display("FAIL %s exec: got %h alu %0d imm %h expected %h alu %0d imm %h",
                     tag, obs, alu_sel, imm, e, ins[4:2], {8'h00, ins[12:5]});
         end
         step;
         #1;
         e = ev(0,0,0,8'(1 << rx),0,0,0,1,0,1,0);
         checks++;
         if (obs !== e) begin fails++; $display("FAIL %s wb: got %h expected %h", tag, obs, e); end
         model_count++;
         step;
      end else if (fmt == 2'b10) begin
         for (int w = 0; w <= waits; w++) begin
            mem_ready = (w == waits);
            #1;
            e = ev({1'b0, ry},0,0,0,0,1,store,store && mem_ready,0,store && mem_ready,0);
            checks++;
            if (obs !== e) begin fails++; $display("FAIL %s mem%0d: got %h expected %h", tag, w, obs, e); end
            step;
         end
         mem_ready = 1'b0;
         if (store) begin
            model_count++;
         end else begin
            #1;
            e = ev(0,0,0,8'(1 << rx),1,0,0,1,0,1,0);
            checks++;
            if (obs !== e) begin fails++; $display("FAIL %s load_wb: got %h expected %h", tag, obs, e); end
            model_count++;
            step;
         end
      end else begin
         #1;
         e = ev(0,0,0,0,0,0,0,!tk,tk,1,0);
         checks++;
         if (obs !== e || pc_target !== ins[15:4]) begin
            fails++;
            $display("FAIL %s branch: got %h tgt %h expected %h tgt %h", tag, obs, pc_target, e, ins[15:4]);
         end
         model_count++;
         step;
      end
      #1;
      checks++;
      if (instr_count !== model_count || instr_ready !== 1'b1) begin
         fails++;
         $display("FAIL %s retire: count %h ready %b expected count %h ready 1",
                  tag, instr_count, instr_ready, model_count);
      end
      $display("txn %s instr=%h count=%h", tag, ins, instr_count);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; instr_valid = 1'b1; instr = 16'h4408; flags = 3'b000; mem_ready = 1'b1;
      step;
      step;
      #1;
      checks++;
      if (obs !== 21'd0 || instr_count !== 16'd0 || imm !== 16'd0 || pc_target !== 12'd0 || alu_sel !== 3'd0) begin
         fails++;
         $display("FAIL reset_state: got %h count %h imm %h tgt %h alu %0d expected all zero",
                  obs, instr_count, imm, pc_target, alu_sel);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (instr_ready !== 1'b0) begin fails++; $display("FAIL reset_idle: ready %b expected 0", instr_ready); end
      step;
      #1;
      checks++;
      if (instr_ready !== 1'b1) begin fails++; $display("FAIL reset_fetch: ready %b expected 1", instr_ready); end
      model_count = 16'd0;
      $display("txn reset released");
   endtask

   task automatic test_alu;
      run_instr(16'h4408, 3'b000, 0, "alu_rr");
      run_instr({3'd7, 8'hA5, 3'd6, 2'b01}, 3'b000, 0, "alu_ri");
   endtask

   task automatic test_mem;
      run_instr({3'd5, 3'd3, 8'h00, 2'b10}, 3'b000, 3, "load_wait3");
      run_instr({3'd1, 3'd6, 8'h01, 2'b10}, 3'b000, 0, "store_ready");
      run_instr({3'd0, 3'd2, 8'h01, 2'b10}, 3'b000, 2, "store_wait2");
   endtask

   task automatic test_branch;
      run_instr({12'h123, 2'b00, 2'b11}, 3'b100, 0, "beq_taken");
      run_instr({12'h123, 2'b00, 2'b11}, 3'b010, 0, "beq_not");
      run_instr({12'h456, 2'b01, 2'b11}, 3'b010, 0, "bgt_taken");
      run_instr({12'h789, 2'b10, 2'b11}, 3'b100, 0, "blt_not");
      run_instr({12'hABC, 2'b11, 2'b11}, 3'b000, 0, "bal_taken");
   endtask

   task automatic test_stall;
      instr_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         instr = 16'($urandom);
         #1;
         checks++;
         if (obs !== ev(0,0,0,0,0,0,0,0,0,0,1) || instr_count !== model_count) begin
            fails++;
            $display("FAIL stall%0d: got %h count %h expected ready only count %h", i, obs, instr_count, model_count);
         end
         step;
      end
      $display("txn stall 4 cycles");
   endtask

   task automatic test_random;
      for (int i = 0; i < 150; i++) begin
         run_instr(16'($urandom), 3'($urandom), int'($urandom_range(0, 3)), "rand");
      end
   endtask

   task automatic test_wrap;
      force dut.instr_count_reg = 16'hFFFF;
      #1;
      release dut.instr_count_reg;
      model_count = 16'hFFFF;
      #1;
      checks++;
      if (instr_count !== 16'hFFFF) begin fails++; $display("FAIL wrap_preset: got %h expected ffff", instr_count); end
      step;
      run_instr({12'h001, 2'b11, 2'b11}, 3'b000, 0, "wrap");
   endtask

   task automatic test_reset_mid;
      instr = {3'd4, 3'd2, 8'h00, 2'b10}; instr_valid = 1'b1; mem_ready = 1'b0;
      step;
      instr_valid = 1'b0;
      #1;
      checks++;
      if (mem_req !== 1'b1 || done !== 1'b0) begin
         fails++;
         $display("FAIL midrst_mem: mem_req %b done %b expected 1 0", mem_req, done);
      end
      rst_n = 1'b0;
      step;
      #1;
      model_count = 16'd0;
      checks++;
      if (obs !== 21'd0 || instr_count !== model_count) begin
         fails++;
         $display("FAIL midrst_abort: got %h count %h expected 0 count 0", obs, instr_count);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (instr_ready !== 1'b0) begin fails++; $display("FAIL midrst_idle: ready %b expected 0", instr_ready); end
      step;
      #1;
      checks++;
      if (instr_ready !== 1'b1) begin fails++; $display("FAIL midrst_fetch: ready %b expected 1", instr_ready); end
      $display("txn reset during mem wait");
      run_instr(16'h4408, 3'b000, 0, "post_rst");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; instr = '0; instr_valid = 1'b0; flags = '0; mem_ready = 1'b0;
      model_count = 16'd0;
      @(negedge clk);
      test_reset;
      test_alu;
      test_mem;
      test_branch;
      test_stall;
      test_random;
      test_wrap;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/bitty_ctrl.md
BITTY_CTRL -- requirements
Module: bitty_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 instr  input  16  instruction word; sampled only on accept (instr_valid && instr_ready).
REQ-004 instr_valid  input  1  instruction source has a word available.
REQ-005 instr_ready  output  1  controller can accept an instruction this cycle.
REQ-006 flags  input  3  {eq,gt,lt} from last compare, read in BRANCH.
REQ-007 mem_ready  input  1  memory completes current request this cycle.
REQ-008 mux_sel  output  4  datapath mux: 0-7 = R0-R7, 8 = imm, others unused.
REQ-009 imm  output  16  zero-extended instr[12:5].
REQ-010 alu_sel  output  3  ALU op = instr[4:2].
REQ-011 en_s  output  1  load S register from mux.
REQ-012 en_c  output  1  load C register with ALU result.
REQ-013 en_reg  output  8  one-hot register-file write enable.
REQ-014 wb_sel  output  1  writeback source: 0 = C, 1 = memory read data.
REQ-015 mem_req, mem_we  output  1 each  memory request / write qualifier.
REQ-016 pc_inc, pc_load  output  1 each  PC +1 / PC <= pc_target.
REQ-017 pc_target  output  12  branch target = instr[15:4].
REQ-018 done  output  1  one-cycle pulse at instruction retirement.
REQ-019 instr_count  output  16  retired-instruction count.

Function
REQ-020 Decode: fmt = instr[1:0]; 00 reg-reg ALU, 01 reg-imm ALU, 10 load/store, 11 branch; Rx = instr[15:13], Ry = instr[12:10]; mem op instr[2]: 0 load, 1 store; branch cond instr[3:2]: 00 eq, 01 gt, 10 lt, 11 always.
REQ-021 Instruction latched into internal register on accept; outputs derive from latched copy, never from live instr.
REQ-022 States: IDLE, FETCH, LOAD_S, EXEC, WB, MEM, BRANCH; all outputs are Moore decodes of state plus latched instr.
REQ-023 IDLE -> FETCH unconditionally; instr_ready = 1 only in FETCH.
REQ-024 FETCH: stay while !instr_valid; on accept go LOAD_S (fmt 00/01), MEM (10), BRANCH (11).
REQ-025 LOAD_S: mux_sel = Rx, en_s = 1 -> EXEC.
REQ-026 EXEC: mux_sel = Ry (fmt 00) or 8 (fmt 01), en_c = 1, alu_sel driven -> WB.
REQ-027 WB: en_reg[Rx] = 1, wb_sel = 0 (ALU) or 1 (load), pc_inc = 1, done = 1 -> FETCH.
REQ-028 MEM: mux_sel = Ry (address), mem_req = 1, mem_we = instr[2]; hold while !mem_ready; mem_ready in same cycle as first mem_req completes that cycle; on completion load -> WB, store -> FETCH with pc_inc = 1, done = 1.
REQ-029 BRANCH: cond true -> pc_load = 1, else pc_inc = 1; done = 1; -> FETCH; pc_inc and pc_load never both 1.
REQ-030 Latency accept-edge to done: ALU 3 cycles, load 2 + mem wait, store 1 + mem wait, branch 1.
REQ-031 en_s, en_c, en_reg, mem_req, pc_inc, pc_load, done are 0 in every state not listed as driving them; at most one en_reg bit high.
REQ-032 instr_count increments by 1 on each done; wraps 0xFFFF -> 0x0000.

Reset
REQ-033 rst_n low at an edge: state = IDLE, latched instr = 0, instr_count = 0, all single-bit outputs 0, mux_sel = 0.
REQ-034 Reset mid-instruction (any state, incl. MEM waiting) aborts it: no done, no en_reg, mem_req drops the next cycle.
REQ-035 First cycle after rst_n rises is IDLE (instr_ready = 0); instr_ready = 1 one cycle later.

Verification
REQ-036 Reset release, instr_valid = 1 held -> instr_ready low for 1 cycle, then high; first accept 2 cycles after release.
REQ-037 instr 0x4408 (fmt 00, Rx=2, Ry=1, alu 2) -> LOAD_S mux_sel=2 en_s; EXEC mux_sel=1 en_c alu_sel=2; WB en_reg=0x04 pc_inc done; instr_count 0 -> 1.
REQ-038 Load, Rx=5, Ry=3, mem_ready after 3 wait cycles -> mem_req high 4 cycles, mem_we=0, mux_sel=3; then WB en_reg=0x20 wb_sel=1.
REQ-039 Store with mem_ready already high -> single MEM cycle, mem_we=1, done same cycle, no en_reg.
REQ-040 Branch cond eq, target 0x123: flags=3'b100 -> pc_load=1 pc_target=0x123; flags=3'b010 -> pc_inc=1; cond always ignores flags.
REQ-041 instr_count preset to 0xFFFF via 65535 retirements (or forced) then one more -> 0x0000; rst_n low during MEM wait -> no done, IDLE next cycle.
